// File: rtl/joystick_pkg.sv
// Shared constants, FSM state type and SPI command-bit helper for the joystick ADC master.
package joystick_pkg;

  localparam int unsigned ADC_W           = 12;
  localparam int unsigned FRAME_BITS      = 17;
  localparam int unsigned DATA_FIRST_EDGE = 6;
  localparam int unsigned EDGE_W          = 5;
  localparam int unsigned ACC_W           = ADC_W + 2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} adc_state_t;

  // Command bit driven before rising edge k: start, SGL, ODD=chan, MSBF, then zeros.
  function automatic logic cmd_bit(input logic [EDGE_W-1:0] k, input logic chan);
    case (k)
      5'd1, 5'd2, 5'd4: return 1'b1;
      5'd3:             return chan;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/joystick_adc_if.sv
// ADC pin bundle plus published joystick results; master = converter, slave = ADC/consumer side.
interface joystick_adc_if;
  import joystick_pkg::*;

  logic             adc_cs_n;
  logic             adc_sclk;
  logic             adc_din;
  logic             adc_dout;
  logic [ADC_W-1:0] x_val;
  logic [ADC_W-1:0] y_val;
  logic             sample_valid;
  logic             sample_chan;

  modport master (
    output adc_cs_n, adc_sclk, adc_din, x_val, y_val, sample_valid, sample_chan,
    input  adc_dout
  );

  modport slave (
    input  adc_cs_n, adc_sclk, adc_din, x_val, y_val, sample_valid, sample_chan,
    output adc_dout
  );
endinterface

// File: rtl/joystick_adc_sclk_gen.sv
// SPI clock divider: CLK_DIV cycles per half-period, low half first, rise/fall strobes and
// a rising-edge index; held idle (sclk low, index 0) whenever en_i is low.
module adc_sclk_gen
  import joystick_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic              sclk_o,
  output logic              rise_c_o,
  output logic              fall_c_o,
  output logic [EDGE_W-1:0] edge_idx_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sclk_q, sclk_d;
  logic [EDGE_W-1:0] idx_q, idx_d;
  logic              half_end;

  always_comb begin
    half_end = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d    = cnt_q + CNT_W'(1);
    sclk_d   = sclk_q;
    idx_d    = idx_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
      idx_d  = '0;
    end else if (half_end) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
      if (!sclk_q) idx_d = idx_q + EDGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      idx_q  <= idx_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign rise_c_o   = half_end && !sclk_q;
  assign fall_c_o   = half_end && sclk_q;
  assign edge_idx_o = idx_q;

endmodule

// File: rtl/joystick_adc.sv
// SPI master for an MCP3202-style 2-channel ADC: converts X and Y alternately and holds results.
// Optional JOYSTICK_AVG_EN: publish the truncated mean of every 4 conversions per channel.
module joystick_adc
  import joystick_pkg::*;
#(
  parameter int unsigned      CLK_DIV   = 25,
  parameter int unsigned      CS_IDLE   = 50,
  parameter logic [ADC_W-1:0] RESET_VAL = 12'h600
) (
  input  logic           clk,
  input  logic           reset,
  joystick_adc_if.master adc
);

  localparam int unsigned IDLE_W = $clog2(CS_IDLE) + 1;

  adc_state_t        state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              chan_q, chan_d;
  logic [ADC_W-1:0]  shift_q, shift_d;
  logic              cs_n_q, cs_n_d;
  logic              din_q, din_d;
  logic [ADC_W-1:0]  x_q, x_d, y_q, y_d;
  logic              valid_q, valid_d;
  logic              vchan_q, vchan_d;
  logic [ADC_W-1:0]  pub_val;
  logic              pub_en;

  logic              sclk;
  logic              rise_c, fall_c;
  logic [EDGE_W-1:0] edge_idx;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk        (clk),
    .rst        (reset),
    .en_i       (state_q == SHIFT),
    .sclk_o     (sclk),
    .rise_c_o   (rise_c),
    .fall_c_o   (fall_c),
    .edge_idx_o (edge_idx)
  );

`ifdef JOYSTICK_AVG_EN
  logic [1:0][ACC_W-1:0] acc_q, acc_d;
  logic [1:0][1:0]       grp_q, grp_d;
  logic [ACC_W-1:0]      sum;
`endif

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    chan_d     = chan_q;
    shift_d    = shift_q;
    din_d      = din_q;
    x_d        = x_q;
    y_d        = y_q;
    valid_d    = 1'b0;
    vchan_d    = vchan_q;
    pub_val    = shift_q;
    pub_en     = 1'b0;
`ifdef JOYSTICK_AVG_EN
    acc_d      = acc_q;
    grp_d      = grp_q;
    sum        = acc_q[chan_q] + ACC_W'(shift_q);
`endif
    case (state_q)
      IDLE: begin
        if (idle_cnt_q == IDLE_W'(CS_IDLE - 1)) begin
          idle_cnt_d = '0;
          state_d    = SHIFT;
          shift_d    = '0;
          din_d      = cmd_bit(EDGE_W'(1), chan_q);
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      SHIFT: begin
        // Edges 1..5 carry the command and null bit; data starts at edge 6.
        if (rise_c && (edge_idx >= EDGE_W'(DATA_FIRST_EDGE - 1)))
          shift_d = {shift_q[ADC_W-2:0], adc.adc_dout};
        if (fall_c) begin
          if (edge_idx == EDGE_W'(FRAME_BITS)) begin
            state_d = DONE;
            din_d   = 1'b0;
`ifdef JOYSTICK_AVG_EN
            if (grp_q[chan_q] == 2'd3) begin
              pub_val       = ADC_W'(sum >> 2);
              pub_en        = 1'b1;
              acc_d[chan_q] = '0;
              grp_d[chan_q] = 2'd0;
            end else begin
              acc_d[chan_q] = sum;
              grp_d[chan_q] = grp_q[chan_q] + 2'd1;
            end
`else
            pub_en = 1'b1;
`endif
          end else begin
            din_d = cmd_bit(edge_idx + EDGE_W'(1), chan_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        chan_d  = ~chan_q;
      end
      default: state_d = IDLE;
    endcase
    // Registered at the SHIFT->DONE edge so results and the pulse appear during DONE.
    if (pub_en) begin
      valid_d = 1'b1;
      vchan_d = chan_q;
      if (chan_q) y_d = pub_val;
      else        x_d = pub_val;
    end
    cs_n_d = (state_d != SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
      chan_q     <= 1'b0;
      shift_q    <= '0;
      cs_n_q     <= 1'b1;
      din_q      <= 1'b0;
      x_q        <= RESET_VAL;
      y_q        <= RESET_VAL;
      valid_q    <= 1'b0;
      vchan_q    <= 1'b0;
`ifdef JOYSTICK_AVG_EN
      acc_q      <= '0;
      grp_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      chan_q     <= chan_d;
      shift_q    <= shift_d;
      cs_n_q     <= cs_n_d;
      din_q      <= din_d;
      x_q        <= x_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      vchan_q    <= vchan_d;
`ifdef JOYSTICK_AVG_EN
      acc_q      <= acc_d;
      grp_q      <= grp_d;
`endif
    end
  end

  assign adc.adc_cs_n     = cs_n_q;
  assign adc.adc_sclk     = sclk;
  assign adc.adc_din      = din_q;
  assign adc.x_val        = x_q;
  assign adc.y_val        = y_q;
  assign adc.sample_valid = valid_q;
  assign adc.sample_chan  = vchan_q;

endmodule

// File: tb/tb_joystick_adc.sv
// Bench for joystick_adc: behavioural MCP3202 model feeding a scoreboard of expected publishes.
module tb_joystick_adc;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_IDLE = 3;
  localparam logic [11:0] RV      = 12'h600;

  typedef struct packed {logic chan; logic [11:0] val;} exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  joystick_adc_if bus ();

  joystick_adc #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .adc   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [11:0] xq[$], yq[$];
  logic [11:0] x_def, y_def, cur_x, cur_y;
  int          edge_cnt = 0;
  logic        frame_chan = 1'b0;
  logic [11:0] frame_val = '0;
  logic [16:0] din_rec = '0;
  int          vectors, miscompares;
`ifdef JOYSTICK_AVG_EN
  logic [13:0] acc [2];
  int          grp [2];
`endif

  // ADC model: records command bits, shifts data on SCLK falls, queues expectation at frame end.
  always @(posedge bus.adc_sclk or negedge bus.adc_sclk or posedge bus.adc_cs_n or posedge reset) begin
    if (reset || bus.adc_cs_n) begin
      if (!reset && edge_cnt == 17) begin
`ifdef JOYSTICK_AVG_EN
        acc[frame_chan] = acc[frame_chan] + 14'(frame_val);
        grp[frame_chan] = grp[frame_chan] + 1;
        if (grp[frame_chan] == 4) begin
          exp_q.push_back({frame_chan, 12'(acc[frame_chan] / 4)});
          acc[frame_chan] = '0;
          grp[frame_chan] = 0;
        end
`else
        exp_q.push_back({frame_chan, frame_val});
`endif
      end
      if (reset) begin
        exp_q.delete();
`ifdef JOYSTICK_AVG_EN
        acc[0] = '0; acc[1] = '0; grp[0] = 0; grp[1] = 0;
`endif
      end
      edge_cnt    = 0;
      bus.adc_dout = 1'b0;
    end else if (bus.adc_sclk) begin
      if (edge_cnt < 17) edge_cnt = edge_cnt + 1;
      if (edge_cnt == 1) din_rec = '0;
      din_rec[edge_cnt-1] = bus.adc_din;
      if (edge_cnt == 3) begin
        frame_chan = bus.adc_din;
        if (frame_chan) begin
          if (yq.size() > 0) frame_val = yq.pop_front();
          else               frame_val = y_def;
        end else begin
          if (xq.size() > 0) frame_val = xq.pop_front();
          else               frame_val = x_def;
        end
      end
    end else if (edge_cnt >= 5 && edge_cnt < 17) begin
      bus.adc_dout = frame_val[16-edge_cnt];
    end
  end

  task automatic do_reset(input logic [11:0] xd, input logic [11:0] yd);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    xq.delete(); yq.delete();
    x_def = xd; y_def = yd;
    cur_x = RV; cur_y = RV;
    reset = 1'b0;
  endtask

  task automatic get_pulse(output bit ok, output logic ch, output logic [11:0] x, output logic [11:0] y);
    ok = 1'b0; ch = 1'b0; x = '0; y = '0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        ok = 1'b1; ch = bus.sample_chan; x = bus.x_val; y = bus.y_val;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.adc_cs_n, bus.adc_sclk, bus.adc_din, bus.sample_valid, bus.sample_chan} !== 5'b10000) begin
      $display("FAIL reset_ctrl got %b expected 10000",
               {bus.adc_cs_n, bus.adc_sclk, bus.adc_din, bus.sample_valid, bus.sample_chan});
      miscompares++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.x_val, bus.y_val} !== {RV, RV}) begin
      $display("FAIL reset_vals got x=%h y=%h expected %h", bus.x_val, bus.y_val, RV);
      miscompares++;
    end
  endtask

  task automatic test_frame();
    bit ok; logic ch; logic [11:0] x, y; exp_t e; int lo, hi;
    do_reset(12'h7A3, 12'h2C1);
    for (int p = 0; p < 2; p++) begin
      get_pulse(ok, ch, x, y);
      vectors++;
      if (!ok || exp_q.size() == 0) begin
        $display("FAIL frame_pulse%0d got ok=%0d queued=%0d expected a pulse", p, ok, exp_q.size());
        miscompares++;
      end else begin
        e = exp_q.pop_front();
        if (e.chan) cur_y = e.val; else cur_x = e.val;
        if ({ch, x, y} !== {e.chan, cur_x, cur_y}) begin
          $display("FAIL frame_pulse%0d got ch=%0d x=%h y=%h expected ch=%0d x=%h y=%h",
                   p, ch, x, y, e.chan, cur_x, cur_y);
          miscompares++;
        end
      end
    end
    vectors++;
    if ({ch, x, y} !== {1'b1, 12'h7A3, 12'h2C1}) begin
      $display("FAIL frame_values got ch=%0d x=%h y=%h expected ch=1 x=7a3 y=2c1", ch, x, y);
      miscompares++;
    end
    lo = 0; hi = 0;
    for (int i = 0; i < 300 && bus.adc_cs_n; i++) @(negedge clk);
    for (int i = 0; i < 300 && !bus.adc_cs_n; i++) begin lo++; @(negedge clk); end
    for (int i = 0; i < 300 && bus.adc_cs_n; i++) begin hi++; @(negedge clk); end
    vectors++;
    if (lo != 68) begin
      $display("FAIL cs_low_len got %0d expected 68", lo);
      miscompares++;
    end
    vectors++;
    if (hi != 4) begin
      $display("FAIL cs_high_len got %0d expected 4", hi);
      miscompares++;
    end
  endtask

  task automatic test_din();
    bit ok; logic ch; logic [11:0] x, y; logic [16:0] want;
    do_reset(12'h123, 12'h456);
    for (int p = 0; p < 2; p++) begin
      get_pulse(ok, ch, x, y);
      want = (p == 0) ? 17'h0000B : 17'h0000F;
      vectors++;
      if (!ok || din_rec !== want) begin
        $display("FAIL din_frame%0d got ok=%0d bits=%h expected %h", p, ok, din_rec, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_extremes();
    bit ok; logic ch; logic [11:0] x, y; exp_t e;
    do_reset(12'h000, 12'hFFF);
    for (int p = 0; p < 2; p++) begin
      get_pulse(ok, ch, x, y);
      vectors++;
      if (!ok || exp_q.size() == 0) begin
        $display("FAIL extreme_pulse%0d got ok=%0d queued=%0d expected a pulse", p, ok, exp_q.size());
        miscompares++;
      end else begin
        e = exp_q.pop_front();
        if (e.chan) cur_y = e.val; else cur_x = e.val;
        if ({ch, x, y} !== {e.chan, cur_x, cur_y}) begin
          $display("FAIL extreme_pulse%0d got ch=%0d x=%h y=%h expected ch=%0d x=%h y=%h",
                   p, ch, x, y, e.chan, cur_x, cur_y);
          miscompares++;
        end
      end
    end
    vectors++;
    if ({x, y} !== {12'h000, 12'hFFF}) begin
      $display("FAIL extreme_values got x=%h y=%h expected x=000 y=fff", x, y);
      miscompares++;
    end
  endtask

  task automatic test_mid_frame_reset();
    bit ok, found; logic ch; logic [11:0] x, y; exp_t e;
    do_reset(12'h155, 12'h2AA);
    get_pulse(ok, ch, x, y);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.adc_cs_n && bus.adc_sclk && edge_cnt == 9) begin found = 1'b1; break; end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (!ok || !found || {bus.adc_cs_n, bus.adc_sclk, bus.sample_valid, bus.y_val} !== {3'b100, RV}) begin
      $display("FAIL abort_async got ok=%0d found=%0d cs_sclk_v=%b y=%h expected 100 y=%h",
               ok, found, {bus.adc_cs_n, bus.adc_sclk, bus.sample_valid}, bus.y_val, RV);
      miscompares++;
    end
    do_reset(12'h155, 12'h2AA);
    get_pulse(ok, ch, x, y);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      $display("FAIL abort_next got ok=%0d queued=%0d expected a pulse", ok, exp_q.size());
      miscompares++;
    end else begin
      e = exp_q.pop_front();
      if ({ch, x, y} !== {e.chan, e.val, RV} || ch !== 1'b0) begin
        $display("FAIL abort_next got ch=%0d x=%h y=%h expected ch=0 x=%h y=%h", ch, x, y, e.val, RV);
        miscompares++;
      end
    end
  endtask

`ifdef JOYSTICK_AVG_EN
  task automatic test_average();
    bit ok; logic ch; logic [11:0] x, y; exp_t e;
    do_reset(12'h000, 12'h2C1);
    xq.push_back(12'h100); xq.push_back(12'h200); xq.push_back(12'h300); xq.push_back(12'h401);
    for (int p = 0; p < 2; p++) begin
      get_pulse(ok, ch, x, y);
      vectors++;
      if (!ok || exp_q.size() == 0) begin
        $display("FAIL avg_pulse%0d got ok=%0d queued=%0d expected a pulse", p, ok, exp_q.size());
        miscompares++;
      end else begin
        e = exp_q.pop_front();
        if (e.chan) cur_y = e.val; else cur_x = e.val;
        if ({ch, x, y} !== {e.chan, cur_x, cur_y}) begin
          $display("FAIL avg_pulse%0d got ch=%0d x=%h y=%h expected ch=%0d x=%h y=%h",
                   p, ch, x, y, e.chan, cur_x, cur_y);
          miscompares++;
        end
      end
      if (p == 0) begin
        vectors++;
        if ({ch, x, y} !== {1'b0, 12'h280, RV}) begin
          $display("FAIL avg_first got ch=%0d x=%h y=%h expected ch=0 x=280 y=%h", ch, x, y, RV);
          miscompares++;
        end
      end
    end
  endtask
`else
  task automatic test_sequence();
    bit ok; logic ch; logic [11:0] x, y; exp_t e; logic [11:0] want [4]; int nx;
    want[0] = 12'h100; want[1] = 12'h200; want[2] = 12'h300; want[3] = 12'h401;
    do_reset(12'h000, 12'h2C1);
    xq.push_back(12'h100); xq.push_back(12'h200); xq.push_back(12'h300); xq.push_back(12'h401);
    nx = 0;
    for (int p = 0; p < 8; p++) begin
      get_pulse(ok, ch, x, y);
      vectors++;
      if (!ok || exp_q.size() == 0) begin
        $display("FAIL seq_pulse%0d got ok=%0d queued=%0d expected a pulse", p, ok, exp_q.size());
        miscompares++;
      end else begin
        e = exp_q.pop_front();
        if (e.chan) cur_y = e.val; else cur_x = e.val;
        if ({ch, x, y} !== {e.chan, cur_x, cur_y}) begin
          $display("FAIL seq_pulse%0d got ch=%0d x=%h y=%h expected ch=%0d x=%h y=%h",
                   p, ch, x, y, e.chan, cur_x, cur_y);
          miscompares++;
        end
        if (ch == 1'b0 && nx < 4) begin
          vectors++;
          if (x !== want[nx]) begin
            $display("FAIL seq_x%0d got %h expected %h", nx, x, want[nx]);
            miscompares++;
          end
          nx++;
        end
      end
    end
    vectors++;
    if (nx != 4) begin
      $display("FAIL seq_x_count got %0d expected 4", nx);
      miscompares++;
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    x_def = RV; y_def = RV; cur_x = RV; cur_y = RV;
    #1;
    test_reset();
    test_frame();
    test_din();
    test_extremes();
    test_mid_frame_reset();
`ifdef JOYSTICK_AVG_EN
    test_average();
`else
    test_sequence();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
